// File: rtl/qs_chk.sv
// Output-side checker for the quicksort packet stream: verifies framing, length
// and ascending order per packet, emits a status record and keeps saturating counters.
module qs_chk #(
  parameter int unsigned W     = 32,
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LEN_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_err,
  input  logic [W-1:0]     in_dat,
  input  logic             clr,
  output logic             stat_vld_r,
  output logic [LEN_W-1:0] stat_len_r,
  output logic             stat_ord_err_r,
  output logic             stat_frm_err_r,
  output logic             stat_dev_err_r,
  output logic [W-1:0]     stat_xor_r,
  output logic [CNT_W-1:0] pkt_cnt_r,
  output logic [CNT_W-1:0] err_cnt_r
);

  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic [W-1:0]       prev, prev_nx;
  logic [W-1:0]       acc, acc_nx;
  logic               ord, ord_nx;
  logic               frm, frm_nx;

  logic               done;
  logic [LEN_W-1:0]   done_len;
  logic               done_ord, done_frm, done_dev;
  logic [W-1:0]       done_xor;
  logic               extra;

  logic [1:0]         err_inc;
  logic [SUM_W-1:0]   err_sum;
  logic [CNT_W-1:0]   err_cnt_nx, pkt_cnt_nx;

  // Next-state, working registers and packet completion record
  always_comb begin
    state_nx = state;
    len_nx   = len;
    prev_nx  = prev;
    acc_nx   = acc;
    ord_nx   = ord;
    frm_nx   = frm;
    done     = 1'b0;
    done_len = len;
    done_ord = ord;
    done_frm = frm;
    done_dev = 1'b0;
    done_xor = acc;
    extra    = 1'b0;

    case (state)
      IDLE: begin
        if (in_vld) begin
          if (in_sop) begin
            len_nx  = LEN_W'(1);
            prev_nx = in_dat;
            acc_nx  = in_dat;
            ord_nx  = 1'b0;
            frm_nx  = 1'b0;
            if (in_eop) begin
              done     = 1'b1;
              done_len = LEN_W'(1);
              done_ord = 1'b0;
              done_frm = 1'b0;
              done_dev = in_err;
              done_xor = in_dat;
            end else begin
              state_nx = PKT;
            end
          end else begin
            extra = 1'b1;
          end
        end
      end
      PKT: begin
        if (in_vld) begin
          if (in_sop) begin
            // Truncated packet: close it without folding in the new sop word
            done     = 1'b1;
            done_frm = 1'b1;
            extra    = 1'b1;
            state_nx = IDLE;
          end else begin
            ord_nx = ord | (in_dat < prev);
            if (len == LEN_W'(N)) frm_nx = 1'b1;
            else                  len_nx = len + LEN_W'(1);
            prev_nx = in_dat;
            acc_nx  = acc ^ in_dat;
            if (in_eop) begin
              done     = 1'b1;
              done_len = len_nx;
              done_ord = ord_nx;
              done_frm = frm_nx;
              done_dev = in_err;
              done_xor = acc_nx;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Saturating counter updates; up to two error events in one cycle
  always_comb begin
    err_inc    = {1'b0, done & (done_ord | done_frm | done_dev)} + {1'b0, extra};
    err_sum    = {1'b0, err_cnt_r} + SUM_W'(err_inc);
    err_cnt_nx = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    pkt_cnt_nx = pkt_cnt_r;
    if (done && (pkt_cnt_r != {CNT_W{1'b1}})) pkt_cnt_nx = pkt_cnt_r + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      len            <= '0;
      prev           <= '0;
      acc            <= '0;
      ord            <= 1'b0;
      frm            <= 1'b0;
      stat_vld_r     <= 1'b0;
      stat_len_r     <= '0;
      stat_ord_err_r <= 1'b0;
      stat_frm_err_r <= 1'b0;
      stat_dev_err_r <= 1'b0;
      stat_xor_r     <= '0;
      pkt_cnt_r      <= '0;
      err_cnt_r      <= '0;
    end else begin
      state      <= state_nx;
      len        <= len_nx;
      prev       <= prev_nx;
      acc        <= acc_nx;
      ord        <= ord_nx;
      frm        <= frm_nx;
      stat_vld_r <= done;
      if (done) begin
        stat_len_r     <= done_len;
        stat_ord_err_r <= done_ord;
        stat_frm_err_r <= done_frm;
        stat_dev_err_r <= done_dev;
        stat_xor_r     <= done_xor;
      end
      pkt_cnt_r <= clr ? '0 : pkt_cnt_nx;
      err_cnt_r <= clr ? '0 : err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_qs_chk.sv
// Directed bench for qs_chk: per-cycle vector table plus hand-written sequences
// for oversize packets, mid-packet reset and counter saturation (CNT_W=4).
module tb_qs_chk;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LEN_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld, in_sop, in_eop, in_err, clr;
  logic [W-1:0]     in_dat;
  logic             stat_vld_r;
  logic [LEN_W-1:0] stat_len_r;
  logic             stat_ord_err_r, stat_frm_err_r, stat_dev_err_r;
  logic [W-1:0]     stat_xor_r;
  logic [CNT_W-1:0] pkt_cnt_r, err_cnt_r;

  int errors = 0;
  int checks = 0;

  // Expected held status record, updated only when a pulse is expected
  logic [LEN_W-1:0] h_len;
  logic             h_ord, h_frm, h_dev;
  logic [W-1:0]     h_xor;

  typedef struct {
    logic             vld, sop, eop, err;
    logic [W-1:0]     dat;
    logic             clr;
    logic             sv;
    logic [LEN_W-1:0] len;
    logic             ord, frm, dev;
    logic [W-1:0]     x;
    logic [CNT_W-1:0] pc, ec;
  } vec_t;

  vec_t vecs[$];

  qs_chk #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err), .in_dat(in_dat),
    .clr(clr),
    .stat_vld_r(stat_vld_r), .stat_len_r(stat_len_r),
    .stat_ord_err_r(stat_ord_err_r), .stat_frm_err_r(stat_frm_err_r),
    .stat_dev_err_r(stat_dev_err_r), .stat_xor_r(stat_xor_r),
    .pkt_cnt_r(pkt_cnt_r), .err_cnt_r(err_cnt_r)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, s, e, er, input logic [W-1:0] d, input logic c,
                              input logic sv, input logic [LEN_W-1:0] len,
                              input logic o, f, dv, input logic [W-1:0] x,
                              input logic [CNT_W-1:0] pc, ec);
    vec_t r;
    r.vld = v; r.sop = s; r.eop = e; r.err = er; r.dat = d; r.clr = c;
    r.sv = sv; r.len = len; r.ord = o; r.frm = f; r.dev = dv; r.x = x; r.pc = pc; r.ec = ec;
    return r;
  endfunction

  task automatic pulse_exp(input logic [LEN_W-1:0] len, input logic o, f, dv, input logic [W-1:0] x);
    h_len = len; h_ord = o; h_frm = f; h_dev = dv; h_xor = x;
  endtask

  task automatic chk(input string nm, input logic sv, input logic [CNT_W-1:0] pc, ec);
    checks++;
    if ({stat_vld_r, stat_len_r, stat_ord_err_r, stat_frm_err_r, stat_dev_err_r, stat_xor_r, pkt_cnt_r, err_cnt_r}
        !== {sv, h_len, h_ord, h_frm, h_dev, h_xor, pc, ec}) begin
      errors++;
      $display("FAIL %s: got vld=%0b len=%0d ord=%0b frm=%0b dev=%0b xor=%h pkt=%0d err=%0d; want vld=%0b len=%0d ord=%0b frm=%0b dev=%0b xor=%h pkt=%0d err=%0d",
               nm, stat_vld_r, stat_len_r, stat_ord_err_r, stat_frm_err_r, stat_dev_err_r, stat_xor_r,
               pkt_cnt_r, err_cnt_r, sv, h_len, h_ord, h_frm, h_dev, h_xor, pc, ec);
    end
  endtask

  // Apply one cycle of inputs at a negedge, return at the next negedge
  task automatic cyc(input logic v, s, e, er, input logic [W-1:0] d, input logic c);
    in_vld = v; in_sop = s; in_eop = e; in_err = er; in_dat = d; clr = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    in_vld = 0; in_sop = 0; in_eop = 0; in_err = 0; in_dat = '0; clr = 0;
    pulse_exp('0, 0, 0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("reset", 0, 0, 0);
    rst = 1'b1;

    //            vld sop eop err dat  clr   sv len ord frm dev xor   pc ec
    vecs.push_back(mk(1, 1, 0, 0, 32'd3, 0,  0, 0, 0, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'd5, 0,  0, 0, 0, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'd5, 0,  0, 0, 0, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'd9, 0,  1, 4, 0, 0, 0, 32'hA, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0, 0,  0, 0, 0, 0, 0, 0,     1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'd7, 0,  0, 0, 0, 0, 0, 0,     1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'd2, 0,  0, 0, 0, 0, 0, 0,     1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'd8, 0,  1, 3, 1, 0, 0, 32'hD, 2, 1));
    vecs.push_back(mk(1, 1, 1, 1, 32'd4, 0,  1, 1, 0, 0, 1, 32'h4, 3, 2));
    vecs.push_back(mk(1, 1, 1, 0, 32'h10, 0, 1, 1, 0, 0, 0, 32'h10, 4, 2));
    vecs.push_back(mk(1, 1, 0, 0, 32'd1, 0,  0, 0, 0, 0, 0, 0,     4, 2));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0, 0,  0, 0, 0, 0, 0, 0,     4, 2));
    vecs.push_back(mk(1, 0, 0, 0, 32'd2, 0,  0, 0, 0, 0, 0, 0,     4, 2));
    vecs.push_back(mk(1, 1, 0, 0, 32'd6, 0,  1, 2, 0, 1, 0, 32'h3, 5, 4));
    vecs.push_back(mk(1, 1, 0, 0, 32'd7, 0,  0, 0, 0, 0, 0, 0,     5, 4));
    vecs.push_back(mk(1, 0, 1, 0, 32'd8, 0,  1, 2, 0, 0, 0, 32'hF, 6, 4));
    vecs.push_back(mk(1, 0, 0, 0, 32'd5, 0,  0, 0, 0, 0, 0, 0,     6, 5));
    vecs.push_back(mk(1, 0, 0, 0, 32'd6, 0,  0, 0, 0, 0, 0, 0,     6, 6));
    vecs.push_back(mk(1, 1, 0, 0, 32'd9, 0,  0, 0, 0, 0, 0, 0,     6, 6));
    vecs.push_back(mk(1, 0, 1, 0, 32'd3, 1,  1, 2, 1, 0, 0, 32'hA, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0, 0,  0, 0, 0, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 32'd4, 0,  0, 0, 0, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'd5, 0,  1, 1, 0, 1, 0, 32'h4, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 32'd0, 0,  0, 0, 0, 0, 0, 0,     1, 2));

    foreach (vecs[i]) begin
      cyc(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].err, vecs[i].dat, vecs[i].clr);
      if (vecs[i].sv) pulse_exp(vecs[i].len, vecs[i].ord, vecs[i].frm, vecs[i].dev, vecs[i].x);
      chk($sformatf("vec[%0d]", i), vecs[i].sv, vecs[i].pc, vecs[i].ec);
    end

    // 18-word ascending packet: length saturates at N, one pulse after eop
    for (int i = 1; i <= 18; i++) begin
      cyc(1, i == 1, i == 18, 0, W'(i), 0);
      if (i == 18) begin
        pulse_exp(LEN_W'(N), 0, 1, 0, 32'h13);
        chk("long_eop", 1, 2, 3);
      end else begin
        chk($sformatf("long_w%0d", i), 0, 1, 2);
      end
    end

    // Reset mid-packet abandons it; then a fresh [1,2]
    cyc(1, 1, 0, 0, 32'd1, 0);
    cyc(1, 0, 0, 0, 32'd2, 0);
    cyc(1, 0, 0, 0, 32'd3, 0);
    chk("rst_pre", 0, 2, 3);
    rst = 1'b0;
    pulse_exp('0, 0, 0, 0, '0);
    cyc(1, 0, 1, 1, 32'd4, 0);
    chk("rst_0", 0, 0, 0);
    cyc(0, 0, 0, 0, 32'd0, 0);
    chk("rst_1", 0, 0, 0);
    rst = 1'b1;
    cyc(1, 1, 0, 0, 32'd1, 0);
    chk("rst_sop", 0, 0, 0);
    cyc(1, 0, 1, 0, 32'd2, 0);
    pulse_exp(2, 0, 0, 0, 32'h3);
    chk("rst_eop", 1, 1, 0);
    cyc(0, 0, 0, 0, 32'd0, 0);
    chk("rst_gap", 0, 1, 0);

    // Counter saturation with 4-bit counters
    cyc(0, 0, 0, 0, 32'd0, 1);
    chk("clr", 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 1, 1, 1, W'(k), 0);
      pulse_exp(1, 0, 0, 1, W'(k));
      chk($sformatf("sat_pkt%0d", k), 1, CNT_W'(k < 15 ? k : 15), CNT_W'(k < 15 ? k : 15));
    end
    cyc(1, 0, 0, 0, 32'd9, 0);
    chk("sat_orphan", 0, 15, 15);
    cyc(0, 0, 0, 0, 32'd0, 1);
    chk("clr2", 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      cyc(1, 0, 0, 0, W'(k), 0);
      chk($sformatf("orphan%0d", k), 0, 0, CNT_W'(k));
    end
    cyc(1, 1, 0, 0, 32'd1, 0);
    chk("sat2_sop", 0, 0, 14);
    cyc(1, 1, 0, 0, 32'd2, 0);
    pulse_exp(1, 0, 1, 0, 32'h1);
    chk("sat2_trunc", 1, 1, 15);
    cyc(0, 0, 0, 0, 32'd0, 0);
    chk("sat2_gap", 0, 1, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
